// File: rtl/reg_wb_ctrl_if.sv
// Bundle of the writeback controller's upstream, decode and register-file
// signals. The controller takes the slave view; whoever feeds it takes master.
interface reg_wb_ctrl_if #(
  parameter int W     = 8,
  parameter int D     = 4,
  parameter int DEPTH = 2
);
  // Upstream result push
  logic                         in_valid;
  logic                         in_ready;
  logic [D-1:0]                 in_addr;
  logic [W-1:0]                 in_data;
  logic                         in_is_load;
  logic [W-1:0]                 mem_rdata;
  // Decode read request
  logic                         rd_req;
  logic [D-1:0]                 rd_addr;
  logic                         rd_hazard;
  // Register-file port
  logic                         rf_write_en;
  logic [D-1:0]                 rf_addr;
  logic [W-1:0]                 rf_data;
  // Status
  logic                         empty;
  logic [$clog2(DEPTH+1)-1:0]   count;

  modport master (
    output in_valid, in_addr, in_data, in_is_load, mem_rdata, rd_req, rd_addr,
    input  in_ready, rd_hazard, rf_write_en, rf_addr, rf_data, empty, count
  );

  modport slave (
    input  in_valid, in_addr, in_data, in_is_load, mem_rdata, rd_req, rd_addr,
    output in_ready, rd_hazard, rf_write_en, rf_addr, rf_data, empty, count
  );
endinterface

// File: rtl/reg_wb_ctrl.sv
// Writeback controller: in-order buffer of ALU/load results draining one per
// cycle into the register file, yielding the shared port to decode reads and
// flagging reads of registers that still have a buffered write.
module reg_wb_ctrl #(
  parameter int W     = 8,
  parameter int D     = 4,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  reg_wb_ctrl_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [D-1:0]     addr_q [DEPTH];
  logic [W-1:0]     data_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [PW-1:0]    head_q, tail_q, fill_idx_q;
  logic [CW-1:0]    count_q;
  logic             fill_pend_q;

  logic push, pop, hit;

  // Handshake and drain decisions; all outputs come from registered state
  // plus the decode request, never from the in_* push inputs.
  always_comb begin
    bus.in_ready    = (count_q < CW'(DEPTH));
    bus.empty       = (count_q == '0);
    bus.count       = count_q;
    push            = bus.in_valid && bus.in_ready;
    bus.rf_write_en = !bus.rd_req && !bus.empty && filled_q[head_q];
    pop             = bus.rf_write_en;
    bus.rf_data     = data_q[head_q];
    if (bus.rd_req)       bus.rf_addr = bus.rd_addr;
    else if (bus.empty)   bus.rf_addr = '0;
    else                  bus.rf_addr = addr_q[head_q];
  end

  // Hazard: does any occupied entry (filled or still waiting on its load)
  // target the register decode is reading?
  always_comb begin : hazard_scan
    logic [PW-1:0] off;
    // NOTE: every variable written here gets a default first, so no path
    // through the block leaves it holding an old value (which would infer a latch).
    hit = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head_q;
      if ((CW'(off) < count_q) && (addr_q[i] == bus.rd_addr)) hit = 1'b1;
    end
    bus.rd_hazard = bus.rd_req && hit;
  end

  // Pointers, occupancy, filled flags and the pending-load tracker.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order inside the block.
    if (!reset_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      filled_q    <= '0;
      fill_pend_q <= 1'b0;
      fill_idx_q  <= '0;
    end else begin
      // Fill, push and pop always touch distinct entries: the fill target is
      // unfilled (so not draining) and occupied (so not the tail).
      if (fill_pend_q) filled_q[fill_idx_q] <= 1'b1;
      if (push) begin
        filled_q[tail_q] <= !bus.in_is_load;
        tail_q           <= tail_q + 1'b1;
      end
      if (pop) begin
        filled_q[head_q] <= 1'b0;
        head_q           <= head_q + 1'b1;
      end
      fill_pend_q <= push && bus.in_is_load;
      if (push && bus.in_is_load) fill_idx_q <= tail_q;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // Entry payload: written on push, and data patched by the load fill.
  // NOTE: the payload array has no reset; an entry is only ever read while
  // occupied, and occupancy is governed by the reset pointers and count.
  always_ff @(posedge clk) begin
    if (fill_pend_q) data_q[fill_idx_q] <= bus.mem_rdata;
    if (push) begin
      addr_q[tail_q] <= bus.in_addr;
      data_q[tail_q] <= bus.in_data;
    end
  end
endmodule
